// File: rtl/aes_pkg.sv
// Shared types and constants for the AES mode controller: block width,
// mode encodings, controller FSM states and the core-input selection helper.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2,
    MODE_RSV = 2'd3
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_CORE = 2'd2,
    ST_DRAIN     = 2'd3
  } aes_state_e;

  // The reserved encoding behaves exactly like ECB.
  function automatic aes_mode_e norm_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_RSV) ? MODE_ECB : aes_mode_e'(m);
  endfunction

  function automatic logic [BLK_W-1:0] core_input(input aes_mode_e m,
                                                  input logic [BLK_W-1:0] pt,
                                                  input logic [BLK_W-1:0] chain);
    case (m)
      MODE_CBC: return pt ^ chain;
      MODE_CTR: return chain;
      default:  return pt;
    endcase
  endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// Result FIFO between the mode controller and the output stream.
// Extra pointer bit distinguishes full from empty; read data is zero when empty.
module aes_out_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aes_mode_ctrl.sv
// AES block-mode controller (ECB / CBC-encrypt / CTR) feeding an external
// single-request AES core and buffering results in an output FIFO.
module aes_mode_ctrl
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int CTR_W      = 32
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [BLK_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic [CNT_W-1:0] cfg_nblocks,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             core_en,
  output logic [BLK_W-1:0] core_data,
  output logic [BLK_W-1:0] core_key,
  input  logic             core_out_valid,
  input  logic [BLK_W-1:0] core_out,
  output logic             busy,
  output logic             done
);

  aes_state_e       state;
  aes_mode_e        mode_r;
  logic [BLK_W-1:0] key_r;
  logic [BLK_W-1:0] chain;
  logic [BLK_W-1:0] pt_p1;
  logic [CNT_W-1:0] remaining;
  logic             req_out;
  logic             hs;
  logic             abort_job;
  logic             fifo_push;
  logic [BLK_W-1:0] fifo_push_data;
  logic             fifo_empty;
  logic             fifo_full;

  function automatic logic [BLK_W-1:0] ctr_next(input logic [BLK_W-1:0] c);
    return {c[BLK_W-1:CTR_W], c[CTR_W-1:0] + CTR_W'(1)};
  endfunction

  assign abort_job = abort && (state != ST_IDLE);
  // req_out blocks a new request while an aborted one is still in the core.
  assign in_ready  = (state == ST_LOAD) && !fifo_full && !req_out && !abort;
  assign hs        = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign out_valid = !fifo_empty;

  assign fifo_push      = (state == ST_WAIT_CORE) && core_out_valid && !abort;
  assign fifo_push_data = (mode_r == MODE_CTR) ? (core_out ^ pt_p1) : core_out;

  aes_out_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (BLK_W)
  ) u_out_fifo (
    .clk       (AES_clk),
    .rst       (AES_rst),
    .flush     (abort_job),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge AES_clk) begin
    if (hs) pt_p1 <= in_data;
    if ((state == ST_IDLE) && cfg_start) key_r <= cfg_key;
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state     <= ST_IDLE;
      mode_r    <= MODE_ECB;
      chain     <= '0;
      remaining <= '0;
      req_out   <= 1'b0;
      core_en   <= 1'b0;
      core_data <= '0;
      core_key  <= '0;
      done      <= 1'b0;
    end else begin
      core_en <= 1'b0;
      done    <= 1'b0;

      if (hs)                  req_out <= 1'b1;
      else if (core_out_valid) req_out <= 1'b0;

      if (abort_job) begin
        state     <= ST_IDLE;
        remaining <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_start) begin
              mode_r    <= norm_mode(cfg_mode);
              chain     <= cfg_iv;
              remaining <= cfg_nblocks;
              state     <= (cfg_nblocks == '0) ? ST_DRAIN : ST_LOAD;
            end
          end
          // p1: one block handed to the core, plaintext captured for CTR
          ST_LOAD: begin
            if (hs) begin
              core_en   <= 1'b1;
              core_data <= core_input(mode_r, in_data, chain);
              core_key  <= key_r;
              state     <= ST_WAIT_CORE;
            end
          end
          // p2: core result lands in the FIFO; chain advances for next block
          ST_WAIT_CORE: begin
            if (core_out_valid) begin
              case (mode_r)
                MODE_CBC: chain <= core_out;
                MODE_CTR: chain <= ctr_next(chain);
                default:  chain <= chain;
              endcase
              remaining <= remaining - CNT_W'(1);
              state     <= (remaining == CNT_W'(1)) ? ST_DRAIN : ST_LOAD;
            end
          end
          ST_DRAIN: begin
            if (fifo_empty) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: behavioural AES-core stand-in with fixed latency,
// table of mode jobs plus hand sequences for backpressure, abort and reset.
module tb_aes_mode_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int CTR_W      = 32;
  localparam int LAT        = 3;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             AES_clk = 1'b0;
  logic             AES_rst;
  logic             cfg_start;
  logic [1:0]       cfg_mode;
  logic [127:0]     cfg_key;
  logic [127:0]     cfg_iv;
  logic [CNT_W-1:0] cfg_nblocks;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             core_en;
  logic [127:0]     core_data;
  logic [127:0]     core_key;
  logic             core_out_valid;
  logic [127:0]     core_out;
  logic             busy;
  logic             done;

  always #5 AES_clk = ~AES_clk;

  aes_mode_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .CTR_W      (CTR_W)
  ) dut (
    .AES_clk        (AES_clk),
    .AES_rst        (AES_rst),
    .cfg_start      (cfg_start),
    .cfg_mode       (cfg_mode),
    .cfg_key        (cfg_key),
    .cfg_iv         (cfg_iv),
    .cfg_nblocks    (cfg_nblocks),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .core_en        (core_en),
    .core_data      (core_data),
    .core_key       (core_key),
    .core_out_valid (core_out_valid),
    .core_out       (core_out),
    .busy           (busy),
    .done           (done)
  );

  // Cipher stand-in: the FIPS-197 known answer, otherwise a fixed mixing function.
  function automatic logic [127:0] core_model(input logic [127:0] d, input logic [127:0] k);
    if (d == KAT_PT && k == KAT_KEY) return KAT_CT;
    return {d[94:0], d[127:95]} ^ k ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  logic [LAT-1:0] cv = '0;
  logic [127:0]   cd_pipe [LAT] = '{default: '0};
  logic           spur = 1'b0;

  always @(posedge AES_clk) begin
    cv <= {cv[LAT-2:0], core_en};
    cd_pipe[0] <= core_model(core_data, core_key);
    for (int i = 1; i < LAT; i++) cd_pipe[i] <= cd_pipe[i-1];
  end
  assign core_out_valid = cv[LAT-1] | spur;
  assign core_out       = cd_pipe[LAT-1];

  logic [127:0] cd_q[$];
  logic [127:0] out_q[$];
  int en_cnt = 0, done_cnt = 0, hs_cnt = 0;

  always @(negedge AES_clk) begin
    if (!AES_rst) begin
      if (core_en) begin cd_q.push_back(core_data); en_cnt++; end
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (done) done_cnt++;
      if (in_valid && in_ready) hs_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int bound);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", name, bound);
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] key;
    logic [127:0] iv;
    int           n;
    logic [127:0] pt0;
    bit           chk_first;
    logic [127:0] exp_first;
    bit           chk_wrap;
  } vec_t;

  vec_t vt[6];
  logic [127:0] pt_a   [16];
  logic [127:0] exp_cd [16];
  logic [127:0] exp_out[16];

  task automatic build_expect(input vec_t v);
    logic [127:0] chain, cdv, c;
    logic [1:0]   m;
    m = (v.mode == 2'd3) ? 2'd0 : v.mode;
    chain = v.iv;
    for (int i = 0; i < v.n; i++) begin
      pt_a[i] = v.pt0 + 128'(i);
      cdv = (m == 2'd1) ? (pt_a[i] ^ chain) : (m == 2'd2) ? chain : pt_a[i];
      c = core_model(cdv, v.key);
      exp_cd[i]  = cdv;
      exp_out[i] = (m == 2'd2) ? (c ^ pt_a[i]) : c;
      if (m == 2'd1) chain = c;
      if (m == 2'd2) chain = {chain[127:32], chain[31:0] + 32'd1};
    end
  endtask

  task automatic start_job(input logic [1:0] m, input logic [127:0] k,
                           input logic [127:0] iv, input int n);
    @(posedge AES_clk); #1;
    cfg_mode = m; cfg_key = k; cfg_iv = iv; cfg_nblocks = CNT_W'(n); cfg_start = 1'b1;
    @(posedge AES_clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int n, input int bound);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pt_a[i];
      w = 0;
      do begin
        @(negedge AES_clk);
        w++;
      end while (!in_ready && w < bound);
      if (!in_ready) begin
        timeout_fail("feed_in_ready", bound);
        in_valid = 1'b0;
        return;
      end
      @(posedge AES_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound);
    int w = 0;
    while (done_cnt == base && w < bound) begin
      @(negedge AES_clk);
      w++;
    end
    if (done_cnt == base) timeout_fail("wait_done", bound);
  endtask

  task automatic wait_core_en(input int base, input int bound);
    int w = 0;
    do begin
      @(negedge AES_clk);
      w++;
    end while (en_cnt == base && w < bound);
    if (en_cnt == base) timeout_fail("wait_core_en", bound);
  endtask

  task automatic compare_job(input string tag, input int n, input int cb, input int ob,
                             input int eb, input int db);
    chk_int({tag, " core_en count"}, en_cnt - eb, n);
    chk_int({tag, " out count"}, out_q.size() - ob, n);
    chk_int({tag, " done pulses"}, done_cnt - db, 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s core_data[%0d]", tag, i),
          (cb + i < cd_q.size()) ? cd_q[cb + i] : 128'hx, exp_cd[i]);
      chk($sformatf("%s out_data[%0d]", tag, i),
          (ob + i < out_q.size()) ? out_q[ob + i] : 128'hx, exp_out[i]);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cb, ob, eb, db;
    string tag;
    tag = $sformatf("vec%0d", idx);
    build_expect(v);
    cb = cd_q.size(); ob = out_q.size(); eb = en_cnt; db = done_cnt;
    start_job(v.mode, v.key, v.iv, v.n);
    feed(v.n, 200);
    wait_done(db, 200);
    repeat (3) @(posedge AES_clk);
    #1;
    compare_job(tag, v.n, cb, ob, eb, db);
    if (v.chk_first)
      chk({tag, " first out"}, (ob < out_q.size()) ? out_q[ob] : 128'hx, v.exp_first);
    if (v.chk_wrap) begin
      chk({tag, " ctr wrap low"}, {96'd0, (cb + 1 < cd_q.size()) ? cd_q[cb+1][31:0] : 32'hx}, 128'd0);
      chk({tag, " ctr wrap high"}, {32'd0, (cb + 1 < cd_q.size()) ? cd_q[cb+1][127:32] : 96'hx},
          {32'd0, v.iv[127:32]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int cb, ob, eb, db, hb;

    vt[0] = '{2'd0, KAT_KEY, 128'd0, 1, KAT_PT, 1'b1, KAT_CT, 1'b0};
    vt[1] = '{2'd1, KAT_KEY, 128'd0, 2, KAT_PT, 1'b1, KAT_CT, 1'b0};
    vt[2] = '{2'd2, KAT_KEY, 128'h0123456789abcdef02468ace_ffffffff, 2,
              128'hdeadbeef000000001111111122222222, 1'b0, 128'd0, 1'b1};
    vt[3] = '{2'd3, 128'hffeeddccbbaa99887766554433221100, 128'd5, 3,
              128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'd0, 1'b0};
    vt[4] = '{2'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0, 4,
              128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'd0, 1'b0};
    vt[5] = '{2'd2, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 3,
              128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, 128'd0, 1'b0};

    AES_rst = 1'b1; cfg_start = 1'b0; cfg_mode = 2'd0; cfg_key = '0; cfg_iv = '0;
    cfg_nblocks = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    repeat (3) @(posedge AES_clk);
    @(negedge AES_clk);
    chk_int("reset in_ready", in_ready, 0);
    chk_int("reset out_valid", out_valid, 0);
    chk_int("reset core_en", core_en, 0);
    chk_int("reset busy", busy, 0);
    chk_int("reset done", done, 0);
    chk("reset out_data", out_data, 128'd0);
    chk("reset core_data", core_data, 128'd0);
    chk("reset core_key", core_key, 128'd0);
    @(posedge AES_clk); #1;
    AES_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Zero-block job: done without touching the core or the FIFO
    cb = cd_q.size(); ob = out_q.size(); eb = en_cnt; db = done_cnt;
    start_job(2'd0, KAT_KEY, 128'd0, 0);
    @(negedge AES_clk);
    chk_int("zero busy", busy, 1);
    wait_done(db, 50);
    repeat (3) @(posedge AES_clk);
    #1;
    chk_int("zero done pulses", done_cnt - db, 1);
    chk_int("zero core_en", en_cnt - eb, 0);
    chk_int("zero out count", out_q.size() - ob, 0);
    chk_int("zero busy after", busy, 0);

    // Backpressure: 10 blocks with out_ready held low, stray cfg_start mid-job
    v = '{2'd0, 128'h0a1b2c3d4e5f60718293a4b5c6d7e8f9, 128'd0, 10,
          128'h11111111222222223333333344444444, 1'b0, 128'd0, 1'b0};
    build_expect(v);
    cb = cd_q.size(); ob = out_q.size(); eb = en_cnt; db = done_cnt; hb = hs_cnt;
    out_ready = 1'b0;
    start_job(v.mode, v.key, v.iv, v.n);
    fork
      feed(v.n, 600);
      begin
        repeat (40) @(posedge AES_clk);
        @(negedge AES_clk);
        chk_int("bp handshakes", hs_cnt - hb, FIFO_DEPTH);
        chk_int("bp in_ready", in_ready, 0);
        chk_int("bp out_valid", out_valid, 1);
        chk_int("bp busy", busy, 1);
        @(posedge AES_clk); #1;
        cfg_mode = 2'd2; cfg_nblocks = CNT_W'(1); cfg_iv = '1; cfg_start = 1'b1;
        @(posedge AES_clk); #1;
        cfg_start = 1'b0;
        repeat (5) @(posedge AES_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done(db, 300);
    repeat (3) @(posedge AES_clk);
    #1;
    compare_job("bp", v.n, cb, ob, eb, db);

    // Abort while the core holds a request
    db = done_cnt; ob = out_q.size(); eb = en_cnt;
    start_job(2'd1, KAT_KEY, 128'd0, 3);
    in_valid = 1'b1;
    in_data  = KAT_PT;
    wait_core_en(eb, 50);
    in_valid = 1'b0;
    abort = 1'b1;
    @(posedge AES_clk); #1;
    abort = 1'b0;
    @(negedge AES_clk);
    chk_int("abort busy", busy, 0);
    chk_int("abort out_valid", out_valid, 0);
    repeat (10) @(negedge AES_clk);
    chk_int("abort late out_valid", out_valid, 0);
    chk_int("abort done pulses", done_cnt - db, 0);
    chk_int("abort out count", out_q.size() - ob, 0);
    run_vec(vt[1], 11);

    // Spurious core_out_valid while idle
    @(posedge AES_clk); #1;
    spur = 1'b1;
    @(posedge AES_clk); #1;
    spur = 1'b0;
    @(negedge AES_clk);
    chk_int("spur out_valid", out_valid, 0);
    chk_int("spur busy", busy, 0);

    // Reset in the middle of a job
    db = done_cnt; eb = en_cnt;
    start_job(2'd0, 128'h55555555aaaaaaaa55555555aaaaaaaa, 128'd0, 3);
    in_valid = 1'b1;
    in_data  = 128'h1234;
    wait_core_en(eb, 50);
    in_valid = 1'b0;
    AES_rst = 1'b1;
    @(posedge AES_clk); #1;
    AES_rst = 1'b0;
    @(negedge AES_clk);
    chk_int("midrst busy", busy, 0);
    chk_int("midrst core_en", core_en, 0);
    chk_int("midrst out_valid", out_valid, 0);
    chk("midrst core_key", core_key, 128'd0);
    repeat (10) @(negedge AES_clk);
    chk_int("midrst done pulses", done_cnt - db, 0);
    chk_int("midrst late out_valid", out_valid, 0);
    run_vec(vt[0], 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
